// File: rtl/bus_timer_responder.sv
// Memory-mapped timer responder: reload, prescaled counter, control/status and overflow count.
// Define TIMER_SYSTICK_EN to build the free-running SYSTICK register at offset 0x10.
module bus_timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h40000020,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout
);

    localparam logic [15:0] PscLast = 16'(PRESCALE - 1);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        pend_q, pend_d;
    logic [7:0]  ovf_q, ovf_d, ovf_base;
    logic [15:0] psc_q, psc_d;
`ifdef TIMER_SYSTICK_EN
    logic [31:0] systick_q, systick_d;
`endif

    logic       sel;
    logic [2:0] off;
    logic       wr_th, wr_tl, wr_tcon, wr_ovf;
    logic       tick, ovf_evt;

    always_comb begin
        sel     = (addr[31:5] == BASE_ADDR[31:5]) && (addr[1:0] == 2'b00);
        off     = addr[4:2];
        wr_th   = wr && sel && (off == 3'd0);
        wr_tl   = wr && sel && (off == 3'd1);
        wr_tcon = wr && sel && (off == 3'd2);
        wr_ovf  = wr && sel && (off == 3'd3);
        tick    = en_q && (psc_q == PscLast);
        ovf_evt = tick && (tl_q == 32'hFFFF_FFFF);
    end

    always_comb begin
        th_d = wr_th ? wdata : th_q;

        // Bus write beats the hardware update; a reload always uses the pre-write TH.
        tl_d = tl_q;
        if (wr_tl) begin
            tl_d = wdata;
        end else if (ovf_evt) begin
            tl_d = th_q;
        end else if (tick) begin
            tl_d = tl_q + 32'd1;
        end

        psc_d = psc_q;
        if (wr_tcon && (wdata[0] != en_q)) begin
            psc_d = '0;
        end else if (en_q) begin
            psc_d = tick ? 16'd0 : psc_q + 16'd1;
        end

        en_d = wr_tcon ? wdata[0] : en_q;
        ie_d = wr_tcon ? wdata[1] : ie_q;
        // Software can only clear PEND; a same-edge overflow still sets it.
        pend_d = (wr_tcon ? (pend_q & wdata[2]) : pend_q) | (ovf_evt & ie_q);

        ovf_base = wr_ovf ? 8'd0 : ovf_q;
        ovf_d    = (ovf_evt && (ovf_base != 8'hFF)) ? ovf_base + 8'd1 : ovf_base;

`ifdef TIMER_SYSTICK_EN
        systick_d = systick_q + 32'd1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            pend_q    <= 1'b0;
            ovf_q     <= '0;
            psc_q     <= '0;
`ifdef TIMER_SYSTICK_EN
            systick_q <= '0;
`endif
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            en_q      <= en_d;
            ie_q      <= ie_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            psc_q     <= psc_d;
`ifdef TIMER_SYSTICK_EN
            systick_q <= systick_d;
`endif
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && sel) begin
            case (off)
                3'd0:    rdata = th_q;
                3'd1:    rdata = tl_q;
                3'd2:    rdata = {29'd0, pend_q, ie_q, en_q};
                3'd3:    rdata = {24'd0, ovf_q};
`ifdef TIMER_SYSTICK_EN
                3'd4:    rdata = systick_q;
`endif
                default: rdata = '0;
            endcase
        end
    end

    assign irqout = ie_q & pend_q;

endmodule

// File: tb/tb_bus_timer_responder.sv
// Bench for bus_timer_responder: two instances (PRESCALE 1 and 4) on one bus, checked against
// a cycle-level reference model of the register rules. Honours TIMER_SYSTICK_EN.
module tb_bus_timer_responder;

    localparam logic [31:0] B0 = 32'h40000020;
    localparam logic [31:0] B1 = 32'h40000040;

    logic        clk, rst_n, rd, wr;
    logic [31:0] addr, wdata, rdata0, rdata1;
    logic        irq0, irq1;

    bus_timer_responder #(.BASE_ADDR(B0), .PRESCALE(1)) dut0 (
        .clk(clk), .reset(rst_n), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .irqout(irq0)
    );
    bus_timer_responder #(.BASE_ADDR(B1), .PRESCALE(4)) dut1 (
        .clk(clk), .reset(rst_n), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .irqout(irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] th, tl;
        logic        en, ie, pend;
        int unsigned ovf, psc;
    } tmr_t;

    tmr_t        m [2];
    logic [31:0] st;
    int          total = 0;
    int          bad = 0;
    logic [31:0] rd_obs0, rd_obs1;
    logic        irq_obs0;

    function automatic logic [31:0] base_of(int k);
        return (k == 0) ? B0 : B1;
    endfunction

    function automatic int unsigned pre_of(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic bit hit(int k, logic [31:0] a);
        logic [31:0] b;
        b = base_of(k);
        return (a[31:5] == b[31:5]) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] mread(int k, logic [31:0] a);
        if (!hit(k, a)) return 32'd0;
        case (a[4:0])
            5'h00: return m[k].th;
            5'h04: return m[k].tl;
            5'h08: return {29'd0, m[k].pend, m[k].ie, m[k].en};
            5'h0C: return 32'(m[k].ovf);
`ifdef TIMER_SYSTICK_EN
            5'h10: return st;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m[k].th = 0; m[k].tl = 0; m[k].en = 0; m[k].ie = 0; m[k].pend = 0;
            m[k].ovf = 0; m[k].psc = 0;
        end
        st = 0;
    endtask

    // One clock edge of the register rules, for both instances.
    task automatic mstep(input logic w, input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < 2; k++) begin
            tmr_t o;
            tmr_t n;
            bit   tk;
            bit   ov;
            o  = m[k];
            n  = o;
            tk = o.en && (o.psc == pre_of(k) - 1);
            ov = tk && (o.tl == 32'hFFFFFFFF);
            if (o.en) n.psc = tk ? 0 : o.psc + 1;
            if (tk) n.tl = ov ? o.th : o.tl + 32'd1;
            if (ov) begin
                n.ovf = (o.ovf < 255) ? o.ovf + 1 : 255;
                if (o.ie) n.pend = 1'b1;
            end
            if (w && hit(k, a)) begin
                case (a[4:0])
                    5'h00: n.th = d;
                    5'h04: n.tl = d;
                    5'h08: begin
                        if (d[0] != o.en) n.psc = 0;
                        n.en   = d[0];
                        n.ie   = d[1];
                        n.pend = (o.pend && d[2]) || (ov && o.ie);
                    end
                    5'h0C: n.ovf = ov ? 1 : 0;
                    default: ;
                endcase
            end
            m[k] = n;
        end
        st = st + 32'd1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one bus cycle, check combinational outputs mid-cycle, then advance the model.
    task automatic bus(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
        rd = r; wr = w; addr = a; wdata = d;
        @(negedge clk);
        rd_obs0  = rdata0;
        rd_obs1  = rdata1;
        irq_obs0 = irq0;
        chk("rdata0", rdata0, r ? mread(0, a) : 32'd0);
        chk("rdata1", rdata1, r ? mread(1, a) : 32'd0);
        chk("irq0", {31'd0, irq0}, {31'd0, m[0].ie & m[0].pend});
        chk("irq1", {31'd0, irq1}, {31'd0, m[1].ie & m[1].pend});
        @(posedge clk);
        mstep(w, a, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        mreset();
        repeat (2) @(posedge clk);
        #1;
        rd = 1'b1; addr = B0 + 32'h4;
        #1;
        chk("rst_rdata", rdata0, 32'd0);
        chk("rst_irq", {31'd0, irq0}, 32'd0);
        rst_n = 1'b1;

        // Reset values across the whole window, plus a misaligned access
        for (int j = 0; j < 8; j++) bus(1'b1, 1'b0, B0 + 32'(4 * j), 32'd0);
        bus(1'b1, 1'b0, 32'h40000022, 32'd0);
        chk("misaligned", rd_obs0, 32'd0);

        // Basic overflow with IRQ on the PRESCALE=1 instance
        bus(1'b0, 1'b1, B0 + 32'h0, 32'hFFFFFFFC);
        bus(1'b0, 1'b1, B0 + 32'h4, 32'hFFFFFFFE);
        bus(1'b0, 1'b1, B0 + 32'h8, 32'd3);
        bus(1'b1, 1'b0, B0 + 32'h4, 32'd0);
        chk("tl_fe", rd_obs0, 32'hFFFFFFFE);
        bus(1'b1, 1'b0, B0 + 32'h4, 32'd0);
        chk("tl_ff", rd_obs0, 32'hFFFFFFFF);
        chk("irq_pre", {31'd0, irq_obs0}, 32'd0);
        bus(1'b1, 1'b0, B0 + 32'h4, 32'd0);
        chk("tl_reload", rd_obs0, 32'hFFFFFFFC);
        chk("irq_set", {31'd0, irq_obs0}, 32'd1);
        bus(1'b1, 1'b0, B0 + 32'hC, 32'd0);
        chk("ovf_one", rd_obs0, 32'd1);
        bus(1'b0, 1'b1, B0 + 32'h8, 32'd3);
        // Clear lands; the same cycle's write of 3 collides with the next overflow edge
        bus(1'b0, 1'b1, B0 + 32'h8, 32'd3);
        chk("irq_cleared", {31'd0, irq_obs0}, 32'd0);
        bus(1'b1, 1'b0, B0 + 32'h8, 32'd0);
        chk("pend_kept", rd_obs0, 32'd7);
        chk("irq_kept", {31'd0, irq_obs0}, 32'd1);
        idle(2);
        bus(1'b0, 1'b1, B0 + 32'h4, 32'd5);
        bus(1'b1, 1'b0, B0 + 32'h4, 32'd0);
        chk("tl_write_wins", rd_obs0, 32'd5);

        // Prescale and hold on the PRESCALE=4 instance
        bus(1'b0, 1'b1, B1 + 32'h4, 32'd0);
        bus(1'b0, 1'b1, B1 + 32'h8, 32'd1);
        for (int j = 0; j <= 8; j++) begin
            bus(1'b1, 1'b0, B1 + 32'h4, 32'd0);
            if (j == 4) chk("psc_tl1", rd_obs1, 32'd1);
            if (j == 8) chk("psc_tl2", rd_obs1, 32'd2);
        end
        bus(1'b0, 1'b1, B1 + 32'h8, 32'd0);
        for (int j = 0; j < 10; j++) bus(1'b1, 1'b0, B1 + 32'h4, 32'd0);
        chk("tl_frozen", rd_obs1, 32'd2);

        // Saturation with IRQ masked on the PRESCALE=1 instance
        bus(1'b0, 1'b1, B0 + 32'h8, 32'd0);
        bus(1'b0, 1'b1, B0 + 32'h8, 32'd0);
        bus(1'b0, 1'b1, B0 + 32'h0, 32'hFFFFFFFF);
        bus(1'b0, 1'b1, B0 + 32'h4, 32'hFFFFFFFF);
        bus(1'b0, 1'b1, B0 + 32'hC, 32'd0);
        bus(1'b0, 1'b1, B0 + 32'h8, 32'd1);
        for (int j = 0; j <= 260; j++) begin
            bus(1'b1, 1'b0, B0 + 32'hC, 32'd0);
            if (j == 254) chk("ovf_254", rd_obs0, 32'd254);
            if (j == 255) chk("ovf_255", rd_obs0, 32'd255);
        end
        chk("ovf_sat", rd_obs0, 32'd255);
        chk("irq_masked", {31'd0, irq_obs0}, 32'd0);
        bus(1'b0, 1'b1, B0 + 32'hC, 32'd0);
        bus(1'b1, 1'b0, B0 + 32'hC, 32'd0);
        chk("ovf_write_collide", rd_obs0, 32'd1);
        bus(1'b0, 1'b1, B0 + 32'h8, 32'd0);
        bus(1'b0, 1'b1, B0 + 32'hC, 32'd0);
        bus(1'b1, 1'b0, B0 + 32'hC, 32'd0);
        chk("ovf_cleared", rd_obs0, 32'd0);

        // Randomized traffic across both instances and stray addresses
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, d;
            int          k;
            k = int'($urandom_range(0, 1));
            a = base_of(k) + 32'($urandom_range(0, 7) * 4);
            case ($urandom_range(0, 9))
                0: a = a + 32'($urandom_range(1, 3));
                1: a = a + 32'h40;
                default: ;
            endcase
            d = $urandom;
            if (a[4:0] == 5'h04 && $urandom_range(0, 1) == 1) d = 32'hFFFFFFF0 | (d & 32'hF);
            if (a[4:0] == 5'h00 && $urandom_range(0, 1) == 1) d = 32'hFFFFFFF8 | (d & 32'h7);
            if (a[4:0] == 5'h08 && $urandom_range(0, 2) != 0) d = d | 32'd1;
            bus(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, d);
        end

        // Asynchronous reset in the middle of a cycle
        bus(1'b0, 1'b1, B0 + 32'h8, 32'd3);
        rd = 1'b1; addr = B0 + 32'h8;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rdata", rdata0, 32'd0);
        chk("async_irq", {31'd0, irq0}, 32'd0);
        mreset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // SYSTICK
        idle(7);
        bus(1'b1, 1'b0, B0 + 32'h10, 32'd0);
`ifdef TIMER_SYSTICK_EN
        chk("systick_7", rd_obs0, 32'd7);
`else
        chk("systick_absent", rd_obs0, 32'd0);
`endif
        bus(1'b0, 1'b1, B0 + 32'h10, 32'h12345678);
        bus(1'b1, 1'b0, B0 + 32'h10, 32'd0);
`ifdef TIMER_SYSTICK_EN
        chk("systick_ro", rd_obs0, 32'd9);
`else
        chk("systick_ro", rd_obs0, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
